user_register_bank: RTL
=======================

# user_register_bank

Parameter register file and run-control register between the Ethernet host-side command decoder and the user application. The host writes parameters and pulses a run request. The user application polls the run flag, clears it, and reads or writes parameter registers through the register32 req/ack handshake. Read data returns on a separate valid strobe.

## Interface
- NUM_REGS, 16, number of 32-bit parameter registers; must be ≤ 256
- ADDR_WIDTH, 8, address width on both the host and user sides
- clk  in  1  sole clock
- reset  in  1  asynchronous, active-low reset
- hostWriteEn  in  1  host write strobe, one-cycle
- hostReadEn  in  1  host read strobe, one-cycle
- hostAddress  in  ADDR_WIDTH  host register address
- hostWriteData  in  32  host write data
- hostReadData  out  32  host read data; registered
- hostRunSet  in  1  pulse that sets the run flag
- userRunValue  out  1  run flag
- userRunClear  in  1  clears the run flag
- runOverrun  out  1  sticky: hostRunSet arrived while the run flag was already 1
- addrError  out  1  sticky: an access used an address ≥ NUM_REGS
- register32CmdReq  in  1  user request
- register32CmdAck  out  1  user acknowledge, one-cycle pulse
- register32Address  in  ADDR_WIDTH  user address
- register32WriteEn  in  1  user access type: 1 = write, 0 = read
- register32WriteData  in  32  user write data
- register32ReadDataValid  out  1  user read-return strobe, one-cycle
- register32ReadData  out  32  user read data; held until the next read return

## Operation
- Reset (reset=0, asynchronous):
  - all registers, userRunValue, runOverrun and addrError go to 0
  - hostReadData and register32ReadData go to 0
  - CmdAck and ReadDataValid go to 0
  - FSM goes to IDLE
- User FSM states: IDLE, ACK, RESP.
  - IDLE: if CmdReq=1, capture address, WriteEn and WriteData, then go to ACK.
  - ACK: CmdAck=1 for this cycle only.
    - If CmdReq is still 1, the request is accepted.
    - Accepted write: the register updates at the end of ACK; next state IDLE.
    - Accepted read: next state RESP.
    - If CmdReq=0 in ACK, the request is withdrawn: no effect, next state IDLE.
  - RESP: ReadDataValid=1 and ReadData = register contents sampled at the end of ACK; next state IDLE.
- Only one user request is in flight at a time; CmdReq is ignored outside IDLE.
- Host port:
  - Host writes and reads complete in a single cycle.
  - hostReadData is valid one cycle after hostReadEn.
  - hostReadData holds its value otherwise.
- Write collision: host write and user write to the same register in the same cycle → the host value wins. The user transaction still completes normally.
- Out of range (address ≥ NUM_REGS):
  - writes are dropped
  - reads return 32'h0
  - addrError is set; it is cleared only by reset
- Run flag:
  - hostRunSet sets it; userRunClear clears it.
  - hostRunSet and userRunClear in the same cycle → flag stays or becomes 1, so the set wins.
  - hostRunSet while the flag is 1 → runOverrun is set (sticky).

## Timing
- User read: CmdReq rises at cycle t → CmdAck at t+1 → ReadDataValid at t+2. Minimum of 3 cycles between accepted requests.
- User write: visible to the host and user from cycle t+2.
- Host write: visible at the next cycle, including on the user path when the write lands in the ACK cycle of a read.
- All outputs are registered; no combinational input→output paths.
- Back-to-back requests: a user holding CmdReq high through the ACK cycle, and lowering it after, gets exactly one acceptance.

## Structure
- Shared package contents:
  - NUM_REGS and ADDR_WIDTH defaults
  - FSM state encoding (2 bits: IDLE=0, ACK=1, RESP=2)
  - command-register index constant REG_CMD=0
  - command opcodes: update_D=8'h00, New_X=8'h01, flush_CMD=8'h02
- One sub-module is natural: register_array_32, the NUM_REGS×32 storage with a host write port, a user write port (host priority) and two read ports.

## Test plan
- Host writes 32'h0000_0001 to address 0 and pulses hostRunSet; user reads address 0 → Ack at t+1, ReadDataValid at t+2, ReadData=32'h0000_0001, userRunValue=1.
- User writes 32'hA5A5_0000 to address 3, then host reads address 3 → hostReadData=32'hA5A5_0000 one cycle after hostReadEn.
- Host and user both write address 5 in the same cycle (host 32'h1111_1111, user 32'h2222_2222) → register 5 = 32'h1111_1111.
- User read at address 20 with NUM_REGS=16 → ReadData=0, addrError=1; a later valid access still works.
- hostRunSet twice without a clear → runOverrun=1. hostRunSet and userRunClear in the same cycle → userRunValue=1.
- CmdReq dropped in the ACK cycle → no write occurs and no ReadDataValid. Asserting reset during RESP → all outputs are 0 immediately and the FSM is IDLE.

Source files
------------

// File: rtl/user_register_bank_pkg.sv
// user_register_bank_pkg
//   Shared definitions for the user register bank: default sizing, user-side
//   FSM encoding, command-register index and command opcodes.
package user_register_bank_pkg;

   localparam int unsigned DefNumRegs   = 16;
   localparam int unsigned DefAddrWidth = 8;

   // User-side handshake FSM
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAck  = 2'd1,
      StResp = 2'd2
   } user_state_e;

   // Register 0 carries the host command word
   localparam int unsigned RegCmd = 0;

   // Command opcodes found in the command register
   localparam logic [7:0] OpUpdateD  = 8'h00;
   localparam logic [7:0] OpNewX     = 8'h01;
   localparam logic [7:0] OpFlushCmd = 8'h02;

endpackage

// File: rtl/user_register_bank_array.sv
// register_array_32
//   NumRegs x 32-bit storage.
//   Ports:
//     clk, reset                       clock, async active-low reset
//     host_we_i/host_addr_i/host_wdata_i   host write port (wins on collision)
//     user_we_i/user_addr_i/user_wdata_i   user write port
//     host_raddr_i -> host_rdata_o     combinational read port
//     user_raddr_i -> user_rdata_o     combinational read port
//   Addresses >= NumRegs match no entry: writes are dropped, reads give 0.
module register_array_32 #(
   parameter int unsigned NumRegs   = 16,
   parameter int unsigned AddrWidth = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 host_we_i,
   input  logic [AddrWidth-1:0] host_addr_i,
   input  logic [31:0]          host_wdata_i,
   input  logic                 user_we_i,
   input  logic [AddrWidth-1:0] user_addr_i,
   input  logic [31:0]          user_wdata_i,
   input  logic [AddrWidth-1:0] host_raddr_i,
   output logic [31:0]          host_rdata_o,
   input  logic [AddrWidth-1:0] user_raddr_i,
   output logic [31:0]          user_rdata_o
);

   logic [31:0] mem_q [NumRegs];
   logic [31:0] mem_d [NumRegs];

   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < NumRegs; i++) begin
         if (host_we_i && host_addr_i == AddrWidth'(i)) begin
            mem_d[i] = host_wdata_i;
         end else if (user_we_i && user_addr_i == AddrWidth'(i)) begin
            mem_d[i] = user_wdata_i;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   // Mux-style reads so out-of-range addresses fall through to zero
   always_comb begin
      host_rdata_o = '0;
      user_rdata_o = '0;
      for (int i = 0; i < NumRegs; i++) begin
         if (host_raddr_i == AddrWidth'(i)) host_rdata_o = mem_q[i];
         if (user_raddr_i == AddrWidth'(i)) user_rdata_o = mem_q[i];
      end
   end

endmodule

// File: rtl/user_register_bank.sv
// user_register_bank
//   Parameter register file plus run-control flag shared by the host command
//   decoder (single-cycle access) and the user application (req/ack handshake).
//   Ports:
//     clk, reset                        clock, async active-low reset
//     hostWriteEn/hostReadEn/hostAddress/hostWriteData/hostReadData  host port
//     hostRunSet, userRunClear, userRunValue   run flag set/clear/value
//     runOverrun                        sticky: set while flag already 1
//     addrError                         sticky: out-of-range access seen
//     register32*                       user req/ack/read-return port
//   All outputs come straight from flops.
module user_register_bank
   import user_register_bank_pkg::*;
#(
   parameter int unsigned NUM_REGS   = DefNumRegs,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  hostWriteEn,
   input  logic                  hostReadEn,
   input  logic [ADDR_WIDTH-1:0] hostAddress,
   input  logic [31:0]           hostWriteData,
   output logic [31:0]           hostReadData,
   input  logic                  hostRunSet,
   output logic                  userRunValue,
   input  logic                  userRunClear,
   output logic                  runOverrun,
   output logic                  addrError,
   input  logic                  register32CmdReq,
   output logic                  register32CmdAck,
   input  logic [ADDR_WIDTH-1:0] register32Address,
   input  logic                  register32WriteEn,
   input  logic [31:0]           register32WriteData,
   output logic                  register32ReadDataValid,
   output logic [31:0]           register32ReadData
);

   user_state_e           state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  we_q;
   logic [31:0]           wdata_q;
   logic                  ack_q, valid_q;
   logic [31:0]           rdata_q, host_rdata_q;
   logic                  run_q, overrun_q, addr_err_q;

   logic                  capture, accept, user_wr, rd_capture;
   logic                  host_in_range, user_in_range;
   logic [31:0]           host_rdata, user_rdata, user_rdata_fwd;

   assign host_in_range = 32'(hostAddress) < NUM_REGS;
   assign user_in_range = 32'(addr_q) < NUM_REGS;

   register_array_32 #(
      .NumRegs  (NUM_REGS),
      .AddrWidth(ADDR_WIDTH)
   ) u_array (
      .clk         (clk),
      .reset       (reset),
      .host_we_i   (hostWriteEn),
      .host_addr_i (hostAddress),
      .host_wdata_i(hostWriteData),
      .user_we_i   (user_wr),
      .user_addr_i (addr_q),
      .user_wdata_i(wdata_q),
      .host_raddr_i(hostAddress),
      .host_rdata_o(host_rdata),
      .user_raddr_i(addr_q),
      .user_rdata_o(user_rdata)
   );

   always_comb begin
      state_d    = state_q;
      capture    = 1'b0;
      accept     = 1'b0;
      user_wr    = 1'b0;
      rd_capture = 1'b0;
      case (state_q)
         StIdle: begin
            if (register32CmdReq) begin
               capture = 1'b1;
               state_d = StAck;
            end
         end
         StAck: begin
            // Request still held in the ack cycle means accepted
            if (register32CmdReq) begin
               accept = 1'b1;
               if (we_q) begin
                  user_wr = 1'b1;
                  state_d = StIdle;
               end else begin
                  rd_capture = 1'b1;
                  state_d    = StResp;
               end
            end else begin
               state_d = StIdle;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // A host write landing in the same cycle must be seen by the user read
   always_comb begin
      user_rdata_fwd = user_rdata;
      if (hostWriteEn && hostAddress == addr_q && user_in_range) begin
         user_rdata_fwd = hostWriteData;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         we_q         <= 1'b0;
         wdata_q      <= '0;
         ack_q        <= 1'b0;
         valid_q      <= 1'b0;
         rdata_q      <= '0;
         host_rdata_q <= '0;
         run_q        <= 1'b0;
         overrun_q    <= 1'b0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            addr_q  <= register32Address;
            we_q    <= register32WriteEn;
            wdata_q <= register32WriteData;
         end
         ack_q   <= (state_d == StAck);
         valid_q <= (state_d == StResp);
         if (rd_capture) rdata_q <= user_rdata_fwd;
         if (hostReadEn) host_rdata_q <= host_rdata;
         // Set beats clear
         if (hostRunSet) begin
            run_q <= 1'b1;
         end else if (userRunClear) begin
            run_q <= 1'b0;
         end
         if (hostRunSet && run_q) overrun_q <= 1'b1;
         if (((hostWriteEn || hostReadEn) && !host_in_range) || (accept && !user_in_range)) begin
            addr_err_q <= 1'b1;
         end
      end
   end

   assign hostReadData            = host_rdata_q;
   assign userRunValue            = run_q;
   assign runOverrun              = overrun_q;
   assign addrError               = addr_err_q;
   assign register32CmdAck        = ack_q;
   assign register32ReadDataValid = valid_q;
   assign register32ReadData      = rdata_q;

endmodule
